// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with RAW hazard detection and stall counting.
// Build option: HAZARD_FWD_EN (stall on load-use only; forwarding covers the rest).
module id_ex_stage #(
    parameter int N     = 32,
    parameter int RA_W  = 5,
    parameter int CMD_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [N-1:0]     id_pc,
    input  logic [N-1:0]     reg1,
    input  logic [N-1:0]     reg2,
    input  logic [N-1:0]     id_imm,
    input  logic [RA_W-1:0]  id_src1,
    input  logic [RA_W-1:0]  id_src2,
    input  logic             id_uses_src2,
    input  logic [RA_W-1:0]  id_dest,
    input  logic [CMD_W-1:0] id_exe_cmd,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             id_wb_en,
    input  logic             id_is_imm,
    input  logic             flush,
    input  logic [RA_W-1:0]  mem_dest,
    input  logic             mem_wb_en,
    output logic             ex_valid,
    output logic [N-1:0]     ex_pc,
    output logic [N-1:0]     ex_val1,
    output logic [N-1:0]     ex_val2,
    output logic [N-1:0]     ex_imm,
    output logic [RA_W-1:0]  ex_src1,
    output logic [RA_W-1:0]  ex_src2,
    output logic [RA_W-1:0]  ex_dest,
    output logic [CMD_W-1:0] ex_exe_cmd,
    output logic             ex_mem_r_en,
    output logic             ex_mem_w_en,
    output logic             ex_wb_en,
    output logic             ex_is_imm,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    logic stall_cond;
    logic ex_hit;
`ifndef HAZARD_FWD_EN
    logic mem_hit;
`endif

    // R0 is never written, so a zero destination can never be a producer.
    function automatic logic hit(input logic [RA_W-1:0] src,
                                 input logic [RA_W-1:0] d,
                                 input logic            en);
        return (src == d) && en && (d != '0);
    endfunction

    always_comb begin
`ifdef HAZARD_FWD_EN
        ex_hit = hit(id_src1, ex_dest, ex_mem_r_en & ex_valid)
               | (id_uses_src2
                  & hit(id_src2, ex_dest, ex_mem_r_en & ex_valid));
        stall_cond = id_valid & ex_hit;
`else
        ex_hit = hit(id_src1, ex_dest, ex_wb_en & ex_valid)
               | (id_uses_src2
                  & hit(id_src2, ex_dest, ex_wb_en & ex_valid));
        mem_hit = hit(id_src1, mem_dest, mem_wb_en)
                | (id_uses_src2 & hit(id_src2, mem_dest, mem_wb_en));
        stall_cond = id_valid & (ex_hit | mem_hit);
`endif
        hazard_stall = stall_cond & ~flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_val1     <= '0;
            ex_val2     <= '0;
            ex_imm      <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_dest     <= '0;
            ex_exe_cmd  <= '0;
            ex_mem_r_en <= 1'b0;
            ex_mem_w_en <= 1'b0;
            ex_wb_en    <= 1'b0;
            ex_is_imm   <= 1'b0;
            stall_cnt   <= '0;
        end else if (flush || hazard_stall) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_val1     <= '0;
            ex_val2     <= '0;
            ex_imm      <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_dest     <= '0;
            ex_exe_cmd  <= '0;
            ex_mem_r_en <= 1'b0;
            ex_mem_w_en <= 1'b0;
            ex_wb_en    <= 1'b0;
            ex_is_imm   <= 1'b0;
            if (hazard_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_val1     <= reg1;
            ex_val2     <= reg2;
            ex_imm      <= id_imm;
            ex_src1     <= id_src1;
            ex_src2     <= id_src2;
            ex_dest     <= id_dest;
            ex_exe_cmd  <= id_exe_cmd;
            ex_mem_r_en <= id_mem_r_en & id_valid;
            ex_mem_w_en <= id_mem_w_en & id_valid;
            ex_wb_en    <= id_wb_en & id_valid;
            ex_is_imm   <= id_is_imm;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage.
// Covers the default build; HAZARD_FWD_EN selects the load-use sequence.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, reg1, reg2, id_imm;
    logic [4:0]  id_src1, id_src2, id_dest, mem_dest;
    logic        id_uses_src2;
    logic [3:0]  id_exe_cmd;
    logic        id_mem_r_en, id_mem_w_en, id_wb_en, id_is_imm;
    logic        flush, mem_wb_en;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_val1, ex_val2, ex_imm;
    logic [4:0]  ex_src1, ex_src2, ex_dest;
    logic [3:0]  ex_exe_cmd;
    logic        ex_mem_r_en, ex_mem_w_en, ex_wb_en, ex_is_imm;
    logic        hazard_stall;
    logic [31:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .reg1(reg1), .reg2(reg2), .id_imm(id_imm),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src2(id_uses_src2), .id_dest(id_dest),
        .id_exe_cmd(id_exe_cmd),
        .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en),
        .id_wb_en(id_wb_en), .id_is_imm(id_is_imm),
        .flush(flush), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_imm(ex_imm),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dest(ex_dest),
        .ex_exe_cmd(ex_exe_cmd),
        .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
        .ex_wb_en(ex_wb_en), .ex_is_imm(ex_is_imm),
        .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic        v;
        logic [31:0] pc, r1, r2;
        logic [4:0]  s1, s2;
        logic        us2;
        logic [4:0]  dest;
        logic        wb, rd, fl;
        logic [4:0]  md;
        logic        mwb;
        logic        ehz, ev;
        logic [31:0] epc, ev1, ev2;
        logic [4:0]  edest;
        logic        ewb;
        logic [31:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [4:0] s1, input logic [4:0] s2,
                         input logic us2, input logic [4:0] dest,
                         input logic wb, input logic rd, input logic fl,
                         input logic [4:0] md, input logic mwb);
        id_valid = v; id_pc = pc; reg1 = r1; reg2 = r2;
        id_src1 = s1; id_src2 = s2; id_uses_src2 = us2;
        id_dest = dest; id_wb_en = wb; id_mem_r_en = rd;
        flush = fl; mem_dest = md; mem_wb_en = mwb;
        id_imm = pc + 32'h100; id_exe_cmd = 4'h2;
        id_mem_w_en = 1'b0; id_is_imm = 1'b0;
    endtask

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic [31:0] r1,
        input logic [31:0] r2, input logic [4:0] s1, input logic [4:0] s2,
        input logic us2, input logic [4:0] dest, input logic wb,
        input logic fl, input logic [4:0] md, input logic mwb,
        input logic ehz, input logic ev, input logic [31:0] epc,
        input logic [31:0] ev1, input logic [31:0] ev2,
        input logic [4:0] edest, input logic ewb, input logic [31:0] ecnt);
        vec_t t;
        t.v = v; t.pc = pc; t.r1 = r1; t.r2 = r2; t.s1 = s1; t.s2 = s2;
        t.us2 = us2; t.dest = dest; t.wb = wb; t.rd = 1'b0; t.fl = fl;
        t.md = md; t.mwb = mwb; t.ehz = ehz; t.ev = ev; t.epc = epc;
        t.ev1 = ev1; t.ev2 = ev2; t.edest = edest; t.ewb = ewb;
        t.ecnt = ecnt;
        return t;
    endfunction

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #12;
        chk("reset_valid", {31'd0, ex_valid}, 0);
        chk("reset_cnt", stall_cnt, 0);
        chk("reset_pc", ex_pc, 0);
        rst = 1'b1;
        @(posedge clk); #1;

`ifndef HAZARD_FWD_EN
        //   v  pc     r1 r2 s1 s2 u2 d  wb fl md mwb | hz ev epc    v1 v2 ed wb cnt
        tbl.push_back(mk(1, 32'h40, 7, 9, 1, 2, 1, 3, 1, 0, 0, 0,
                         0, 1, 32'h40, 7, 9, 3, 1, 0));
        tbl.push_back(mk(1, 32'h44, 11, 7, 3, 1, 1, 4, 1, 0, 0, 0,
                         1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h44, 11, 7, 3, 1, 1, 4, 1, 0, 3, 1,
                         1, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 32'h44, 11, 7, 3, 1, 1, 4, 1, 0, 0, 0,
                         0, 1, 32'h44, 11, 7, 4, 1, 2));
        tbl.push_back(mk(1, 32'h48, 1, 2, 2, 5, 1, 0, 1, 0, 4, 1,
                         0, 1, 32'h48, 1, 2, 0, 1, 2));
        tbl.push_back(mk(1, 32'h4c, 0, 0, 0, 0, 1, 4, 1, 0, 0, 1,
                         0, 1, 32'h4c, 0, 0, 4, 1, 2));
        tbl.push_back(mk(1, 32'h50, 3, 0, 1, 0, 0, 5, 1, 0, 4, 1,
                         0, 1, 32'h50, 3, 0, 5, 1, 2));
        tbl.push_back(mk(1, 32'h54, 4, 0, 1, 5, 0, 6, 1, 0, 0, 0,
                         0, 1, 32'h54, 4, 0, 6, 1, 2));
        tbl.push_back(mk(1, 32'h58, 1, 1, 6, 0, 0, 7, 1, 1, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 32'h5c, 1, 1, 1, 9, 1, 7, 1, 0, 9, 1,
                         1, 0, 0, 0, 0, 0, 0, 3));
        tbl.push_back(mk(0, 32'h60, 5, 6, 9, 0, 0, 2, 1, 0, 9, 1,
                         0, 0, 32'h60, 5, 6, 2, 0, 3));
        tbl.push_back(mk(1, 32'h64, 8, 1, 2, 0, 0, 8, 0, 0, 0, 0,
                         0, 1, 32'h64, 8, 1, 8, 0, 3));
        tbl.push_back(mk(1, 32'h68, 2, 3, 8, 0, 0, 9, 1, 0, 0, 0,
                         0, 1, 32'h68, 2, 3, 9, 1, 3));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].r1, tbl[i].r2,
                  tbl[i].s1, tbl[i].s2, tbl[i].us2, tbl[i].dest,
                  tbl[i].wb, tbl[i].rd, tbl[i].fl, tbl[i].md, tbl[i].mwb);
            #2;
            chk($sformatf("v%0d_stall", i), {31'd0, hazard_stall},
                {31'd0, tbl[i].ehz});
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid},
                {31'd0, tbl[i].ev});
            chk($sformatf("v%0d_pc", i), ex_pc, tbl[i].epc);
            chk($sformatf("v%0d_val1", i), ex_val1, tbl[i].ev1);
            chk($sformatf("v%0d_val2", i), ex_val2, tbl[i].ev2);
            chk($sformatf("v%0d_dest", i), {27'd0, ex_dest},
                {27'd0, tbl[i].edest});
            chk($sformatf("v%0d_wb", i), {31'd0, ex_wb_en},
                {31'd0, tbl[i].ewb});
            chk($sformatf("v%0d_cnt", i), stall_cnt, tbl[i].ecnt);
        end
`else
        // ALU producer in EX: forwarded, no stall.
        drive(1, 32'h40, 1, 2, 1, 2, 1, 3, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 32'h44, 5, 1, 3, 1, 1, 4, 1, 0, 0, 0, 0);
        #2;
        chk("fwd_alu_stall", {31'd0, hazard_stall}, 0);
        @(posedge clk); #1;
        chk("fwd_alu_pc", ex_pc, 32'h44);
        chk("fwd_alu_cnt", stall_cnt, 0);
        // MEM producer also never stalls.
        drive(1, 32'h48, 1, 1, 4, 3, 1, 5, 1, 0, 0, 3, 1);
        #2;
        chk("fwd_mem_stall", {31'd0, hazard_stall}, 0);
        @(posedge clk); #1;
        // Load-use: exactly one bubble.
        drive(1, 32'h4c, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0, 0);
        @(posedge clk); #1;
        chk("fwd_lw_rd", {31'd0, ex_mem_r_en}, 1);
        drive(1, 32'h50, 6, 6, 3, 3, 1, 4, 1, 0, 0, 0, 0);
        #2;
        chk("fwd_lu_stall1", {31'd0, hazard_stall}, 1);
        @(posedge clk); #1;
        chk("fwd_lu_bubble", {31'd0, ex_valid}, 0);
        chk("fwd_lu_cnt", stall_cnt, 1);
        drive(1, 32'h50, 6, 6, 3, 3, 1, 4, 1, 0, 0, 3, 1);
        #2;
        chk("fwd_lu_stall2", {31'd0, hazard_stall}, 0);
        @(posedge clk); #1;
        chk("fwd_lu_pc", ex_pc, 32'h50);
        chk("fwd_lu_valid", {31'd0, ex_valid}, 1);
        chk("fwd_lu_cnt2", stall_cnt, 1);
`endif

        // Asynchronous reset mid-run with a live EX instruction.
        drive(1, 32'h70, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("pre_rst_valid", {31'd0, ex_valid}, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, ex_valid}, 0);
        chk("async_rst_pc", ex_pc, 0);
        chk("async_rst_val1", ex_val1, 0);
        chk("async_rst_wb", {31'd0, ex_wb_en}, 0);
        chk("async_rst_cnt", stall_cnt, 0);
        #3;
        rst = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
